// File: rtl/fdiv_sqrt_scheduler.sv
// Two-thread arbiter and result holder for one shared FP div/sqrt unit.
// Define RSD_FDIVSQRT_FLUSH_ABORT_EN to kill the unit on an owner flush.
module fdiv_sqrt_scheduler #(
  parameter int DIV_LAT  = 28,
  parameter int SQRT_LAT = 27,
  parameter int TAG_W    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_is_divide,
  input  logic [1:0][31:0]      req_lhs,
  input  logic [1:0][31:0]      req_rhs,
  input  logic [1:0][2:0]       req_rm,
  input  logic [1:0][TAG_W-1:0] req_tag,
  input  logic [1:0]            flush,
  output logic                  unit_start,
  output logic                  unit_is_divide,
  output logic [31:0]           unit_lhs,
  output logic [31:0]           unit_rhs,
  output logic [2:0]            unit_rm,
  output logic                  unit_abort,
  input  logic [31:0]           unit_result,
  input  logic [4:0]            unit_fflags,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [31:0]           resp_result,
  output logic [4:0]            resp_fflags,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE, BUSY, HOLD, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [5:0]       cnt;
  logic             prio;
  logic             owner;
  logic             start_q;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             accept;
  logic             sel;
  logic             own_flush;
  logic             capture;
  logic [31:0]      res_q;
  logic [4:0]       flg_q;
  logic [TAG_W-1:0] tag_q;

  assign own_flush = flush[owner];
  assign elig      = req_valid & ~flush;
  assign accept    = |grant;
  assign sel       = grant[1];
  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign unit_start  = start_q;
  assign resp_result = res_q;
  assign resp_fflags = flg_q;
  assign resp_tag    = tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant      = 2'b00;
    unit_abort = 1'b0;
    resp_valid = 2'b00;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n) begin
          // Round-robin only matters under contention.
          if (&elig) grant = prio ? 2'b10 : 2'b01;
          else       grant = elig;
        end
        if (|grant) state_nx = BUSY;
      end
      BUSY: begin
        if (own_flush) begin
`ifdef RSD_FDIVSQRT_FLUSH_ABORT_EN
          unit_abort = 1'b1;
          state_nx   = IDLE;
`else
          state_nx = (cnt == 6'd1) ? IDLE : DRAIN;
`endif
        end else if (cnt == 6'd1) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (own_flush) begin
          state_nx = IDLE;
        end else begin
          resp_valid[owner] = 1'b1;
          if (resp_ready[owner]) state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (cnt == 6'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      prio           <= 1'b0;
      owner          <= 1'b0;
      start_q        <= 1'b0;
      unit_is_divide <= 1'b0;
      unit_lhs       <= '0;
      unit_rhs       <= '0;
      unit_rm        <= '0;
      tag_q          <= '0;
      res_q          <= '0;
      flg_q          <= '0;
    end else begin
      start_q <= accept;
      if (accept) begin
        owner          <= sel;
        prio           <= ~sel;
        unit_is_divide <= req_is_divide[sel];
        unit_lhs       <= req_lhs[sel];
        unit_rhs       <= req_rhs[sel];
        unit_rm        <= req_rm[sel];
        tag_q          <= req_tag[sel];
        cnt <= req_is_divide[sel] ? 6'(DIV_LAT)
                                  : 6'(SQRT_LAT);
      end else if (cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end
      if (capture) begin
        res_q <= unit_result;
        flg_q <= unit_fflags;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_sqrt_scheduler.sv
// Randomized bench for fdiv_sqrt_scheduler against a timeline model.
// Honours RSD_FDIVSQRT_FLUSH_ABORT_EN when defined.
module tb_fdiv_sqrt_scheduler;
  localparam int DL   = 28;
  localparam int SL   = 27;
  localparam int TW   = 7;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, req_is_divide;
  logic [1:0][31:0] req_lhs, req_rhs;
  logic [1:0][2:0] req_rm;
  logic [1:0][TW-1:0] req_tag;
  logic [1:0] flush;
  logic unit_start, unit_is_divide, unit_abort;
  logic [31:0] unit_lhs, unit_rhs, unit_result;
  logic [2:0] unit_rm;
  logic [4:0] unit_fflags;
  logic [1:0] resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic [4:0] resp_fflags;
  logic [TW-1:0] resp_tag;
  logic busy;

  always #5 clk = ~clk;

  fdiv_sqrt_scheduler #(
    .DIV_LAT(DL), .SQRT_LAT(SL), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_divide(req_is_divide),
    .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_rm(req_rm), .req_tag(req_tag),
    .flush(flush),
    .unit_start(unit_start),
    .unit_is_divide(unit_is_divide),
    .unit_lhs(unit_lhs), .unit_rhs(unit_rhs),
    .unit_rm(unit_rm), .unit_abort(unit_abort),
    .unit_result(unit_result),
    .unit_fflags(unit_fflags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result),
    .resp_fflags(resp_fflags),
    .resp_tag(resp_tag), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in datapath: deterministic answer for an operation.
  function automatic logic [31:0] f_res(
    input logic d, input logic [31:0] a, input logic [31:0] b);
    return a ^ {b[15:0], b[31:16]} ^ (d ? 32'ha5a5_0000 : 32'h0000_5a5a);
  endfunction

  function automatic logic [4:0] f_flg(
    input logic [31:0] a, input logic [31:0] b);
    return a[4:0] ^ b[9:5];
  endfunction

  // Model: operation timeline in absolute cycle numbers.
  bit m_fly, m_drain, m_hold, m_prio, m_own, m_div;
  int m_acc, m_lat;
  logic [31:0] m_lhs, m_rhs;
  logic [2:0] m_rm;
  logic [TW-1:0] m_tag;
  logic [5:0] seq [2];
  int n_del = 0;

  initial begin
    bit idle, post_rst, done, last_rst;
    logic [1:0] elig, e_rdy, e_rv;
    logic e_abort;
    int g;

    m_fly = 0; m_drain = 0; m_hold = 0; m_prio = 0;
    m_own = 0; m_div = 0; m_acc = 0; m_lat = 0;
    m_lhs = '0; m_rhs = '0; m_rm = '0; m_tag = '0;
    seq[0] = '0; seq[1] = '0;
    last_rst = 1'b0;
    rst_n = 1'b0; req_valid = '0; req_is_divide = '0;
    req_lhs = '0; req_rhs = '0; req_rm = '0;
    req_tag = '0; flush = '0; resp_ready = '0;
    unit_result = '0; unit_fflags = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      post_rst = last_rst;
      rst_n = !(cyc < 2 || cyc % 900 == 450);
      idle = !m_fly && !m_hold;

      for (int t = 0; t < 2; t++) begin
        req_is_divide[t] = 1'($urandom);
        req_lhs[t] = $urandom;
        req_rhs[t] = $urandom;
        req_rm[t]  = 3'($urandom);
        req_tag[t] = {1'(t), seq[t]};
      end
      req_valid = 2'($urandom);
      resp_ready = ($urandom_range(3) != 0) ? 2'($urandom) | 2'b01
                                            : 2'($urandom);
      for (int t = 0; t < 2; t++)
        flush[t] = m_hold ? ($urandom_range(3) == 0)
                          : ($urandom_range(63) == 0);
      if (cyc >= 1000 && cyc < 1040) resp_ready = 2'b01;
      if (cyc >= 2000 && cyc < 2400) begin
        req_valid = 2'b11; flush = 2'b00; resp_ready = 2'b11;
      end
      if (post_rst) begin
        req_valid = 2'b01; flush = 2'b00;
      end
      done = m_fly && (cyc == m_acc + m_lat);
      unit_result = done ? f_res(m_div, m_lhs, m_rhs) : $urandom;
      unit_fflags = done ? f_flg(m_lhs, m_rhs) : 5'($urandom);
      #1;

      elig = req_valid & ~flush;
      e_rdy = 2'b00;
      if (idle && rst_n) begin
        if (elig == 2'b11) e_rdy = m_prio ? 2'b10 : 2'b01;
        else               e_rdy = elig;
      end
      e_rv = 2'b00;
      if (m_hold && !flush[m_own]) e_rv[m_own] = 1'b1;
`ifdef RSD_FDIVSQRT_FLUSH_ABORT_EN
      e_abort = m_fly && !m_drain && flush[m_own];
`else
      e_abort = 1'b0;
`endif

      if (rst_n && cyc >= 2) begin
        chk("busy", 32'(busy), 32'(!idle));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("unit_start", 32'(unit_start),
            32'(m_fly && cyc == m_acc + 1));
        chk("unit_abort", 32'(unit_abort), 32'(e_abort));
        if (!idle) begin
          chk("unit_is_divide", 32'(unit_is_divide), 32'(m_div));
          chk("unit_lhs", unit_lhs, m_lhs);
          chk("unit_rhs", unit_rhs, m_rhs);
          chk("unit_rm", 32'(unit_rm), 32'(m_rm));
        end
        if (m_hold) begin
          chk("resp_result", resp_result, f_res(m_div, m_lhs, m_rhs));
          chk("resp_fflags", 32'(resp_fflags), 32'(f_flg(m_lhs, m_rhs)));
          chk("resp_tag", 32'(resp_tag), 32'(m_tag));
        end
        if (post_rst) begin
          chk("rst_unit_lhs", unit_lhs, 32'h0);
          chk("rst_unit_rhs", unit_rhs, 32'h0);
          chk("rst_unit_rm", 32'(unit_rm), 32'h0);
          chk("rst_unit_div", 32'(unit_is_divide), 32'h0);
          chk("rst_resp_result", resp_result, 32'h0);
          chk("rst_resp_fflags", 32'(resp_fflags), 32'h0);
          chk("rst_resp_tag", 32'(resp_tag), 32'h0);
        end
      end

      if (!rst_n) begin
        m_fly = 0; m_drain = 0; m_hold = 0; m_prio = 0;
      end else if (m_hold) begin
        if (flush[m_own]) m_hold = 0;
        else if (resp_ready[m_own]) begin
          m_hold = 0; n_del++;
        end
      end else if (m_fly) begin
        if (!m_drain && flush[m_own]) begin
`ifdef RSD_FDIVSQRT_FLUSH_ABORT_EN
          m_fly = 0;
`else
          if (done) m_fly = 0;
          else      m_drain = 1;
`endif
        end else if (done) begin
          m_fly = 0;
          if (!m_drain) m_hold = 1;
          m_drain = 0;
        end
      end else if (e_rdy != 2'b00) begin
        g = e_rdy[1] ? 1 : 0;
        m_fly = 1; m_drain = 0; m_own = 1'(g);
        m_prio = !m_own; m_acc = cyc;
        m_div = req_is_divide[g];
        m_lat = m_div ? DL : SL;
        m_lhs = req_lhs[g]; m_rhs = req_rhs[g];
        m_rm = req_rm[g]; m_tag = req_tag[g];
        seq[g] = seq[g] + 6'd1;
      end
      last_rst = !rst_n;
    end

    chk("some_delivered", 32'(n_del > 10), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
